sfu_poly2_eval: RTL

//  Order-2 polynomial evaluation stage of the SFU datapath, directly upstream of post_processor.

---
 rtl/sfu_poly2_eval.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sfu_poly2_eval.sv
// sfu_poly2_eval
//   Order-2 polynomial evaluation stage of the SFU datapath:
//   approximate_result = c0 + c1*dx + c2*dx^2.
//   This is a 3-stage pipeline with a valid/ready handshake on both sides.
//   The sideband fields (precision, opcode, sign, exponent, single_x, skip)
//   ride through the pipeline beside the data and stay aligned with it.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ready does not depend on in_valid
//   in_precision..in_skip
//                        sideband, delayed by 3 stages
//   in_dx                unsigned reduced argument, 0.DX_W
//   in_c0/in_c1/in_c2    signed coefficients, Q2.(Cn_W-2)
//   out_valid/out_ready  downstream handshake
//   precision..skip      sideband to post_processor
//   approximate_result   signed Q4.46 polynomial value; 0 when skip
module sfu_poly2_eval #(
  parameter int DX_W = 16,
  parameter int C0_W = 28,
  parameter int C1_W = 22,
  parameter int C2_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_precision,
  input  logic [3:0]             in_opcode,
  input  logic                   in_sign,
  input  logic [7:0]             in_exponent,
  input  logic [31:0]            in_single_x,
  input  logic                   in_skip,
  input  logic [DX_W-1:0]        in_dx,
  input  logic [C0_W-1:0]        in_c0,
  input  logic [C1_W-1:0]        in_c1,
  input  logic [C2_W-1:0]        in_c2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   precision,
  output logic [3:0]             opcode,
  output logic                   sign,
  output logic [7:0]             exponent,
  output logic [31:0]            single_x,
  output logic                   skip,
  output logic signed [3:-46]    approximate_result
);

  localparam int STAGES = 3;
  localparam int FRAC   = 46;
  localparam int RES_W  = 50;
  localparam int SQ_W   = 2*DX_W;
  // One spare bit on each product so the signed-by-unsigned multiply stays exact.
  localparam int P1_W   = C1_W + DX_W + 1;
  localparam int P2_W   = C2_W + DX_W + 1;
  // Left shifts that line each term up on 46 fraction bits.
  localparam int SH0    = FRAC - (C0_W - 2);
  localparam int SH1    = FRAC - (C1_W - 2 + DX_W);
  localparam int SH2    = FRAC - (C2_W - 2 + DX_W);

  typedef struct packed {
    logic        precision;
    logic [3:0]  opcode;
    logic        sign;
    logic [7:0]  exponent;
    logic [31:0] single_x;
    logic        skip;
  } sb_t;

  logic                 en;
  logic [STAGES:1]      vld_pipe;
  sb_t                  sb_in;
  sb_t [STAGES:1]       sb_pipe;

  // S1 state
  logic [SQ_W-1:0]        sq_1;
  logic signed [P1_W-1:0] p1_1;
  logic [C0_W-1:0]        c0_1;
  logic [C2_W-1:0]        c2_1;
  // S2 state
  logic signed [P2_W-1:0] p2_2;
  logic signed [P1_W-1:0] p1_2;
  logic [C0_W-1:0]        c0_2;

  // All stages share one enable: a stall at the output freezes the whole
  // pipe. Bubbles are not squeezed out.
  assign en       = !vld_pipe[STAGES] || out_ready;
  assign in_ready = en;

  assign sb_in = '{precision: in_precision, opcode: in_opcode, sign: in_sign,
                   exponent: in_exponent, single_x: in_single_x, skip: in_skip};

  // S1 combinational: square of dx and the exact c1*dx product.
  // Both multiplier operands are widened to the product width first, so the
  // truncated two's-complement product is exact.
  logic [SQ_W-1:0]        dx_sq_x, sq_next;
  logic signed [P1_W-1:0] c1_x, dx1_x, p1_next;
  assign dx_sq_x = {{DX_W{1'b0}}, in_dx};
  assign sq_next = dx_sq_x * dx_sq_x;
  assign c1_x    = {{(P1_W-C1_W){in_c1[C1_W-1]}}, in_c1};
  assign dx1_x   = {{(P1_W-DX_W){1'b0}}, in_dx};
  assign p1_next = c1_x * dx1_x;

  // S2 combinational: dx^2 is truncated to its top DX_W bits (no rounding),
  // then multiplied by c2.
  logic [DX_W-1:0]        sqh;
  logic signed [P2_W-1:0] c2_x, sqh_x, p2_next;
  assign sqh     = sq_1[SQ_W-1:DX_W];
  assign c2_x    = {{(P2_W-C2_W){c2_1[C2_W-1]}}, c2_1};
  assign sqh_x   = {{(P2_W-DX_W){1'b0}}, sqh};
  assign p2_next = c2_x * sqh_x;

  // S3 combinational: sign-extend, align to Q4.46 and sum.
  // |sum| < 6, so 50 bits never overflow.
  logic signed [RES_W-1:0] t0, t1, t2, sum;
  assign t0  = {{(RES_W-C0_W){c0_2[C0_W-1]}}, c0_2} << SH0;
  assign t1  = {{(RES_W-P1_W){p1_2[P1_W-1]}}, p1_2} << SH1;
  assign t2  = {{(RES_W-P2_W){p2_2[P2_W-1]}}, p2_2} << SH2;
  assign sum = t0 + t1 + t2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe           <= '0;
      sb_pipe            <= '0;
      sq_1               <= '0;
      p1_1               <= '0;
      c0_1               <= '0;
      c2_1               <= '0;
      p2_2               <= '0;
      p1_2               <= '0;
      c0_2               <= '0;
      approximate_result <= '0;
    end else if (en) begin
      vld_pipe           <= {vld_pipe[STAGES-1:1], in_valid};
      sb_pipe            <= {sb_pipe[STAGES-1:1], sb_in};
      sq_1               <= sq_next;
      p1_1               <= p1_next;
      c0_1               <= in_c0;
      c2_1               <= in_c2;
      p2_2               <= p2_next;
      p1_2               <= p1_1;
      c0_2               <= c0_1;
      // Bypassed beats still take the full latency; only the value is zeroed.
      approximate_result <= sb_pipe[2].skip ? '0 : sum;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign precision = sb_pipe[STAGES].precision;
  assign opcode    = sb_pipe[STAGES].opcode;
  assign sign      = sb_pipe[STAGES].sign;
  assign exponent  = sb_pipe[STAGES].exponent;
  assign single_x  = sb_pipe[STAGES].single_x;
  assign skip      = sb_pipe[STAGES].skip;

endmodule
